// File: rtl/alu_pkg.sv
// Purpose: shared ALU command codes and sequencer FSM state encoding.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_pkg;

    // 4-bit ALU command codes, shared by the ALU and anything that drives it
    localparam logic [3:0] CMD_ADD  = 4'd0;
    localparam logic [3:0] CMD_INC  = 4'd1;
    localparam logic [3:0] CMD_SUB  = 4'd2;
    localparam logic [3:0] CMD_DEC  = 4'd3;
    localparam logic [3:0] CMD_MUL  = 4'd4;
    localparam logic [3:0] CMD_DIV  = 4'd5;
    localparam logic [3:0] CMD_SHL  = 4'd6;
    localparam logic [3:0] CMD_SHR  = 4'd7;
    localparam logic [3:0] CMD_AND  = 4'd8;
    localparam logic [3:0] CMD_OR   = 4'd9;
    localparam logic [3:0] CMD_INV  = 4'd10;
    localparam logic [3:0] CMD_NAND = 4'd11;
    localparam logic [3:0] CMD_NOR  = 4'd12;
    localparam logic [3:0] CMD_XOR  = 4'd13;
    localparam logic [3:0] CMD_XNOR = 4'd14;
    localparam logic [3:0] CMD_BUF  = 4'd15;

    // Result value substituted for a divide by zero
    localparam logic [15:0] DIV_ZERO_RESULT = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_RESULT = 2'd2
    } seq_state_e;

    function automatic logic is_div_by_zero(input logic [3:0] cmd, input logic [7:0] b);
        return (cmd == CMD_DIV) && (b == 8'd0);
    endfunction

endpackage

// File: rtl/alu_op_fifo.sv
// Purpose: synchronous FIFO holding packed ALU requests {a, b, cmd, tag}.
// Latency: written entry visible at the head the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty; full/empty from registered count.
//
// Ports: clk, rst_n; push/wr_dat write side; pop/rd_dat read side (rd_dat = head);
//        full, empty, count status.
module alu_op_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [W-1:0]               wr_dat,
    input  logic                       pop,
    output logic [W-1:0]               rd_dat,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_dat  = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wr_dat;
            // Power-of-two depth: pointers wrap naturally
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: buffers ALU requests, issues one at a time to a combinational ALU, returns registered results.
// Latency: request accepted at edge N from idle -> ISSUE in cycle N+1 -> res_valid from edge N+2.
// Backpressure: in_ready = !full; result held in RESULT until res_ready; max one result per 2 cycles.
//
// Ports: in_* request handshake (a, b, cmd, tag); alu_* / alu_enable drive the ALU, alu_out returns
//        its result; res_* result handshake with data, tag, zero and err flags; count, busy status.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [7:0]                 in_a,
    input  logic [7:0]                 in_b,
    input  logic [3:0]                 in_cmd,
    input  logic [TAG_W-1:0]           in_tag,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic [3:0]                 alu_command,
    output logic                       alu_enable,
    input  logic [15:0]                alu_out,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [15:0]                res_data,
    output logic [TAG_W-1:0]           res_tag,
    output logic                       res_zero,
    output logic                       res_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy
);

    localparam int ENTRY_W = 8 + 8 + 4 + TAG_W;

    seq_state_e         state_q, state_d;
    logic [15:0]        res_data_q, res_data_d;
    logic [TAG_W-1:0]   res_tag_q, res_tag_d;
    logic               res_zero_q, res_zero_d;
    logic               res_err_q, res_err_d;

    logic [ENTRY_W-1:0] head_dat;
    logic [7:0]         head_a;
    logic [7:0]         head_b;
    logic [3:0]         head_cmd;
    logic [TAG_W-1:0]   head_tag;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic               div_zero;
    logic [15:0]        load_data;

    alu_op_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (in_valid),
        .wr_dat ({in_a, in_b, in_cmd, in_tag}),
        .pop    (fifo_pop),
        .rd_dat (head_dat),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (count)
    );

    assign {head_a, head_b, head_cmd, head_tag} = head_dat;

    assign in_ready    = !fifo_full;
    // Head entry is shown whenever present; zeros when the queue is empty
    assign alu_a       = fifo_empty ? 8'd0 : head_a;
    assign alu_b       = fifo_empty ? 8'd0 : head_b;
    assign alu_command = fifo_empty ? 4'd0 : head_cmd;

    // The ALU's own divide-by-zero output is undefined, so substitute a fixed value
    assign div_zero  = is_div_by_zero(head_cmd, head_b);
    assign load_data = div_zero ? DIV_ZERO_RESULT : alu_out;

    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        res_tag_d  = res_tag_q;
        res_zero_d = res_zero_q;
        res_err_d  = res_err_q;
        alu_enable = 1'b0;
        fifo_pop   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (count != '0) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Only reachable with a non-empty queue, so the head is valid here
                alu_enable = 1'b1;
                fifo_pop   = 1'b1;
                res_data_d = load_data;
                res_tag_d  = head_tag;
                res_zero_d = (load_data == 16'd0);
                res_err_d  = div_zero;
                state_d    = ST_RESULT;
            end
            ST_RESULT: begin
                // Registered count: a push landing in the same cycle is seen from IDLE next
                if (res_ready) begin
                    state_d = (count != '0) ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
            res_tag_q  <= '0;
            res_zero_q <= 1'b0;
            res_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
            res_tag_q  <= res_tag_d;
            res_zero_q <= res_zero_d;
            res_err_q  <= res_err_d;
        end
    end

    assign res_valid = (state_q == ST_RESULT);
    assign res_data  = res_data_q;
    assign res_tag   = res_tag_q;
    assign res_zero  = res_zero_q;
    assign res_err   = res_err_q;
    assign busy      = (state_q != ST_IDLE) || (count != '0);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: directed self-checking bench for alu_op_sequencer with a behavioural 8-bit ALU attached.
// Latency: n/a.
// Backpressure: res_ready driven per scenario to exercise stall and drain.
module tb_alu_op_sequencer;
    import alu_pkg::*;

    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   in_valid;
    logic                   in_ready;
    logic [7:0]             in_a;
    logic [7:0]             in_b;
    logic [3:0]             in_cmd;
    logic [TAG_W-1:0]       in_tag;
    logic [7:0]             alu_a;
    logic [7:0]             alu_b;
    logic [3:0]             alu_command;
    logic                   alu_enable;
    logic [15:0]            alu_out;
    logic                   res_valid;
    logic                   res_ready;
    logic [15:0]            res_data;
    logic [TAG_W-1:0]       res_tag;
    logic                   res_zero;
    logic                   res_err;
    logic [$clog2(DEPTH):0] count;
    logic                   busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(
        .DEPTH (DEPTH),
        .TAG_W (TAG_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cmd      (in_cmd),
        .in_tag      (in_tag),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_command (alu_command),
        .alu_enable  (alu_enable),
        .alu_out     (alu_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_tag     (res_tag),
        .res_zero    (res_zero),
        .res_err     (res_err),
        .count       (count),
        .busy        (busy)
    );

    // Behavioural ALU; divide by zero deliberately returns 0 so substitution is observable
    function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                              input logic [3:0] c);
        logic [15:0] r;
        r = 16'd0;
        case (c)
            CMD_ADD:  r = {8'd0, a} + {8'd0, b};
            CMD_INC:  r = {8'd0, a} + 16'd1;
            CMD_SUB:  r = {8'd0, a} - {8'd0, b};
            CMD_DEC:  r = {8'd0, a} - 16'd1;
            CMD_MUL:  r = {8'd0, a} * {8'd0, b};
            CMD_DIV:  r = (b == 8'd0) ? 16'd0 : {8'd0, a / b};
            CMD_SHL:  r = {8'd0, a} << 1;
            CMD_SHR:  r = {8'd0, a >> 1};
            CMD_AND:  r = {8'd0, a & b};
            CMD_OR:   r = {8'd0, a | b};
            CMD_INV:  r = {8'd0, ~a};
            CMD_NAND: r = {8'd0, ~(a & b)};
            CMD_NOR:  r = {8'd0, ~(a | b)};
            CMD_XOR:  r = {8'd0, a ^ b};
            CMD_XNOR: r = {8'd0, ~(a ^ b)};
            default:  r = {8'd0, a};
        endcase
        return r;
    endfunction

    assign alu_out = alu_model(alu_a, alu_b, alu_command);

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [3:0] c,
                        input logic [TAG_W-1:0] t, output bit acc);
        in_a     = a;
        in_b     = b;
        in_cmd   = c;
        in_tag   = t;
        in_valid = 1'b1;
        acc      = in_ready;
        step();
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, then moves past the consuming edge
    task automatic get_result(input string nm, input logic [15:0] d, input logic [TAG_W-1:0] t,
                              input logic z, input logic e);
        int k;
        k = 0;
        while (!res_valid && k < 20) begin
            step();
            k++;
        end
        check({nm, "_vld"}, res_valid, 1);
        if (res_valid) begin
            check({nm, "_dat"}, res_data, d);
            check({nm, "_tag"}, res_tag, t);
            check({nm, "_zero"}, res_zero, z);
            check({nm, "_err"}, res_err, e);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit acc;
        bit acc_v [6];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cmd    = '0;
        in_tag    = '0;
        res_ready = 1'b0;

        // Reset state
        #12;
        check("rst_vld", res_valid, 0);
        check("rst_dat", res_data, 0);
        check("rst_en", alu_enable, 0);
        check("rst_cnt", count, 0);
        check("rst_rdy", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_alu_a", alu_a, 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Single ADD: enable for exactly one cycle, result at N+2
        res_ready = 1'b1;
        push(8'd20, 8'd10, CMD_ADD, 4'd3, acc);
        check("add_acc", acc, 1);
        check("add_n0_en", alu_enable, 0);
        check("add_n0_vld", res_valid, 0);
        step();
        check("add_n1_en", alu_enable, 1);
        check("add_n1_a", alu_a, 20);
        check("add_n1_b", alu_b, 10);
        check("add_n1_cmd", alu_command, CMD_ADD);
        check("add_n1_vld", res_valid, 0);
        step();
        check("add_n2_en", alu_enable, 0);
        check("add_n2_vld", res_valid, 1);
        check("add_n2_dat", res_data, 30);
        check("add_n2_tag", res_tag, 3);
        check("add_n2_zero", res_zero, 0);
        check("add_n2_err", res_err, 0);
        step();
        check("add_n3_vld", res_valid, 0);
        check("add_n3_busy", busy, 0);
        step();

        // Back-to-back SUB/XOR/MUL; third push coincides with the first pop at count 2
        res_ready = 1'b0;
        push(8'd25, 8'd17, CMD_SUB, 4'd1, acc);
        check("b2b_cnt1", count, 1);
        push(8'd15, 8'd15, CMD_XOR, 4'd2, acc);
        check("b2b_cnt2", count, 2);
        push(8'd6, 8'd7, CMD_MUL, 4'd4, acc);
        check("push_pop_cnt", count, 2);
        res_ready = 1'b1;
        get_result("sub", 16'd8, 4'd1, 1'b0, 1'b0);
        get_result("xor", 16'd0, 4'd2, 1'b1, 1'b0);
        get_result("mul", 16'd42, 4'd4, 1'b0, 1'b0);

        // Divide by zero substitution, then a normal divide
        push(8'd9, 8'd0, CMD_DIV, 4'd5, acc);
        get_result("div0", 16'hFFFF, 4'd5, 1'b0, 1'b1);
        push(8'd9, 8'd3, CMD_DIV, 4'd6, acc);
        get_result("div", 16'd3, 4'd6, 1'b0, 1'b0);
        step();

        // Full FIFO with stalled consumer: 5 accepted (1 held + 4 queued), 6th dropped
        res_ready = 1'b0;
        push(8'd1, 8'd2, CMD_ADD, 4'd1, acc_v[0]);
        push(8'd10, 8'd4, CMD_SUB, 4'd2, acc_v[1]);
        push(8'hF0, 8'h0F, CMD_OR, 4'd3, acc_v[2]);
        check("full_held_dat", res_data, 3);
        push(8'd5, 8'd0, CMD_INC, 4'd4, acc_v[3]);
        push(8'd200, 8'd100, CMD_ADD, 4'd5, acc_v[4]);
        check("full_cnt", count, 4);
        check("full_rdy", in_ready, 0);
        push(8'd3, 8'd3, CMD_MUL, 4'd6, acc_v[5]);
        for (int i = 0; i < 6; i++) begin
            check("full_acc", acc_v[i], (i < 5) ? 1 : 0);
        end
        check("full_cnt_after", count, 4);
        step();
        step();
        check("stall_vld", res_valid, 1);
        check("stall_dat", res_data, 3);
        check("stall_tag", res_tag, 1);
        res_ready = 1'b1;
        get_result("drain_a", 16'd3, 4'd1, 1'b0, 1'b0);
        get_result("drain_b", 16'd6, 4'd2, 1'b0, 1'b0);
        get_result("drain_c", 16'h00FF, 4'd3, 1'b0, 1'b0);
        get_result("drain_d", 16'd6, 4'd4, 1'b0, 1'b0);
        get_result("drain_e", 16'd300, 4'd5, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("drain_no_dup", res_valid, 0);
            step();
        end
        check("drain_cnt", count, 0);
        check("drain_busy", busy, 0);

        // Reset in the middle of ISSUE with 3 entries queued
        res_ready = 1'b0;
        push(8'd50, 8'd2, CMD_MUL, 4'd1, acc);
        push(8'd1, 8'd2, CMD_ADD, 4'd2, acc);
        push(8'd3, 8'd4, CMD_ADD, 4'd3, acc);
        push(8'd5, 8'd6, CMD_ADD, 4'd4, acc);
        check("pre_rst_dat", res_data, 100);
        res_ready = 1'b1;
        step();
        check("pre_rst_en", alu_enable, 1);
        check("pre_rst_cnt", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_en", alu_enable, 0);
        check("mid_rst_cnt", count, 0);
        check("mid_rst_vld", res_valid, 0);
        check("mid_rst_dat", res_data, 0);
        check("mid_rst_tag", res_tag, 0);
        check("mid_rst_alu_a", alu_a, 0);
        check("mid_rst_busy", busy, 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        push(8'd1, 8'd1, CMD_ADD, 4'd7, acc);
        get_result("post_rst", 16'd2, 4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_quiet", res_valid, 0);
            step();
        end
        check("post_rst_cnt", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
